fifo_drain: RTL

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_if.sv | 22 ++
 rtl/fifo_drain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_if.sv
// Bus bundle for fifo_drain: FIFO read side plus the valid/ready output stream.
// master = the drainer, slave = the FIFO/downstream environment.
interface fifo_drain_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_drain.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream through a 2-entry buffer.
// Optional transfer counter output xfer_cnt when FIFO_DRAIN_COUNT_EN is defined.
module fifo_drain #(
    parameter int DATA_W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         enable,
    input  logic         flush,
    output logic         busy,
`ifdef FIFO_DRAIN_COUNT_EN
    output logic [15:0]  xfer_cnt,
`endif
    fifo_drain_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              m_valid_q, m_valid_d;
    logic              busy_q, busy_d;
    logic              pop_s, cap_s, rd_en_s;
    logic [2:0]        pending_s;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0]       cnt_q, cnt_d;
`endif

    // Handshake decode: flush overrides pop and capture; a flushed in-flight word is dropped.
    always_comb begin
        pop_s     = m_valid_q & bus.m_ready & ~flush;
        cap_s     = inflight_q & ~flush & (state_q != FLUSH);
        pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        rd_en_s   = resetn & ~flush & (state_q == RUN) & enable & ~bus.fifo_empty
                    & (pending_s < 3'd2);
    end

    // Next-state logic for the IDLE/RUN/FLUSH controller.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    state_d = enable ? RUN : IDLE;
                RUN:     state_d = (!enable && !inflight_q) ? IDLE : RUN;
                FLUSH:   state_d = inflight_q ? FLUSH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Buffer update; entry 0 is always the head so m_data comes straight from a flop.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({cap_s, pop_s})
                2'b10: begin
                    case (occ_q)
                        2'd0: begin buf0_d = bus.fifo_data; occ_d = 2'd1; end
                        2'd1: begin buf1_d = bus.fifo_data; occ_d = 2'd2; end
                        default: occ_d = occ_q;
                    endcase
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_d = bus.fifo_data;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = bus.fifo_data;
                    end
                end
                default: occ_d = occ_q;
            endcase
        end
        inflight_d = rd_en_s;
        m_valid_d  = (occ_d != 2'd0);
        busy_d     = (state_d != IDLE) | (occ_d != 2'd0);
    end

`ifdef FIFO_DRAIN_COUNT_EN
    // Transfer counter, wraps naturally at 16 bits.
    always_comb begin
        if (flush) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = pop_s ? cnt_q + 16'd1 : cnt_q;
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= {DATA_W{1'b0}};
            buf1_q     <= {DATA_W{1'b0}};
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef FIFO_DRAIN_COUNT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            m_valid_q  <= m_valid_d;
            busy_q     <= busy_d;
`ifdef FIFO_DRAIN_COUNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = buf0_q;
    assign busy           = busy_q;
`ifdef FIFO_DRAIN_COUNT_EN
    assign xfer_cnt       = cnt_q;
`endif

    fifo_drain_chk u_chk (
        .clock  (clock),
        .resetn (resetn),
        .cap    (cap_s),
        .pop    (pop_s),
        .occ    (occ_q)
    );
endmodule

// Overflow guard: the read throttle must make a capture into a full buffer impossible.
module fifo_drain_chk (
    input logic       clock,
    input logic       resetn,
    input logic       cap,
    input logic       pop,
    input logic [1:0] occ
);
    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(cap && !pop && (occ == 2'd2)));
endmodule
